// File: rtl/pe_group_weight_buffer_pkg.sv
// pe_group_weight_buffer_pkg: shared PE-group defaults, error-flag encoding and address helper
package pe_group_weight_buffer_pkg;
    localparam int PeAddressCount        = 8;
    localparam int PeAddressCountWidth   = 3;
    localparam int PeDataWidth           = 8;
    localparam int PeEntryReadTimes      = 2;
    localparam int PeEntryReadTimesWidth = 2;

    typedef struct packed {
        logic wr_ovf;
        logic rd_empty;
    } pe_err_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned count);
        return addr < count;
    endfunction
endpackage

// File: rtl/pe_group_entry_tracker.sv
// pe_group_entry_tracker: per-entry occupancy bits and read counters for the weight buffer
module pe_group_entry_tracker
    import pe_group_weight_buffer_pkg::*;
#(
    parameter int AddressCount        = PeAddressCount,
    parameter int AddressCountWidth   = PeAddressCountWidth,
    parameter int EntryReadTimes      = PeEntryReadTimes,
    parameter int EntryReadTimesWidth = PeEntryReadTimesWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [AddressCountWidth-1:0] wr_addr,
    input  logic                         rd_en,
    input  logic [AddressCountWidth-1:0] rd_addr,
    output logic [AddressCount-1:0]      entry_full,
    output logic                         wr_ovf,
    output logic                         rd_empty
);
    localparam logic [EntryReadTimesWidth-1:0] CntOne = 1;

    logic [AddressCount-1:0]                          full_q, full_d;
    logic [AddressCount-1:0][EntryReadTimesWidth-1:0] cnt_q, cnt_d;
    logic                                             rd_frees, same_addr;

    always_comb begin
        full_d    = full_q;
        cnt_d     = cnt_q;
        rd_frees  = 1'b0;
        same_addr = wr_addr == rd_addr;
        if (rd_en && full_q[rd_addr]) begin
            rd_frees         = 32'(cnt_q[rd_addr]) + 1 >= EntryReadTimes;
            full_d[rd_addr]  = ~rd_frees;
            cnt_d[rd_addr]   = rd_frees ? '0 : cnt_q[rd_addr] + CntOne;
        end
        // A same-address write lands after the read update, so it always wins
        if (wr_en) begin
            full_d[wr_addr] = 1'b1;
            cnt_d[wr_addr]  = '0;
        end
        wr_ovf   = wr_en & full_q[wr_addr] & ~(rd_frees & same_addr);
        rd_empty = rd_en & ~full_q[rd_addr] & ~(wr_en & same_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end

    assign entry_full = full_q;
endmodule

// File: rtl/pe_group_weight_buffer.sv
// pe_group_weight_buffer: multi-read weight store with registered read port and sticky error flags
module pe_group_weight_buffer
    import pe_group_weight_buffer_pkg::*;
#(
    parameter int AddressCount        = PeAddressCount,
    parameter int AddressCountWidth   = PeAddressCountWidth,
    parameter int DataWidth           = PeDataWidth,
    parameter int EntryReadTimes      = PeEntryReadTimes,
    parameter int EntryReadTimesWidth = PeEntryReadTimesWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WEn,
    input  logic [AddressCountWidth-1:0] WAddr,
    input  logic [DataWidth-1:0]         WData,
    input  logic                         REn,
    input  logic [AddressCountWidth-1:0] RAddr,
    output logic                         RAccept,
    output logic [DataWidth-1:0]         RData,
    output logic                         RDataValid,
    input  logic                         RDataRdy,
    output logic [AddressCount-1:0]      EntryFull,
    output logic                         Drained,
    output logic                         WrOvfErr,
    output logic                         RdEmptyErr
);
    logic [DataWidth-1:0] mem_q [AddressCount];
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    pe_err_t              err_q, err_d;
    logic                 w_ok, r_ok, bypass, trk_wr_ovf, trk_rd_empty;

    assign w_ok    = addr_in_range(32'(WAddr), AddressCount);
    assign r_ok    = addr_in_range(32'(RAddr), AddressCount);
    assign RAccept = REn & (~rvalid_q | RDataRdy);
    assign bypass  = WEn & w_ok & r_ok & (WAddr == RAddr);

    pe_group_entry_tracker #(
        .AddressCount       (AddressCount),
        .AddressCountWidth  (AddressCountWidth),
        .EntryReadTimes     (EntryReadTimes),
        .EntryReadTimesWidth(EntryReadTimesWidth)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (WEn & w_ok),
        .wr_addr   (WAddr),
        .rd_en     (RAccept & r_ok),
        .rd_addr   (RAddr),
        .entry_full(EntryFull),
        .wr_ovf    (trk_wr_ovf),
        .rd_empty  (trk_rd_empty)
    );

    always_comb begin
        rdata_d         = RAccept ? (bypass ? WData : (r_ok ? mem_q[RAddr] : '0)) : rdata_q;
        rvalid_d        = RAccept | (rvalid_q & ~RDataRdy);
        err_d.wr_ovf    = err_q.wr_ovf | (WEn & ~w_ok) | trk_wr_ovf;
        err_d.rd_empty  = err_q.rd_empty | (RAccept & ~r_ok) | trk_rd_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left unreset; occupancy tracking decides what is valid
    always_ff @(posedge clk) begin
        if (WEn && w_ok) mem_q[WAddr] <= WData;
    end

    assign RData      = rdata_q;
    assign RDataValid = rvalid_q;
    assign Drained    = ~|EntryFull;
    assign WrOvfErr   = err_q.wr_ovf;
    assign RdEmptyErr = err_q.rd_empty;
endmodule

// File: tb/tb_pe_group_weight_buffer.sv
// tb_pe_group_weight_buffer: table-driven plus directed corner-case checks for the weight buffer
module tb_pe_group_weight_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       WEn, REn, RDataRdy;
    logic [2:0] WAddr, RAddr;
    logic [7:0] WData;
    logic       RAccept, RDataValid, Drained, WrOvfErr, RdEmptyErr;
    logic [7:0] RData, EntryFull;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic       wen;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [2:0] raddr;
        logic       rdy;
        logic       acc;
        logic       vld;
        logic [7:0] rdata;
        logic [7:0] full;
    } vec_t;

    vec_t vt [25];

    pe_group_weight_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .WEn       (WEn),
        .WAddr     (WAddr),
        .WData     (WData),
        .REn       (REn),
        .RAddr     (RAddr),
        .RAccept   (RAccept),
        .RData     (RData),
        .RDataValid(RDataValid),
        .RDataRdy  (RDataRdy),
        .EntryFull (EntryFull),
        .Drained   (Drained),
        .WrOvfErr  (WrOvfErr),
        .RdEmptyErr(RdEmptyErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic wen, input logic [2:0] waddr, input logic [7:0] wdata,
                         input logic ren, input logic [2:0] raddr, input logic rdy);
        WEn = wen; WAddr = waddr; WData = wdata;
        REn = ren; RAddr = raddr; RDataRdy = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vt[i].wen = 1'b1; vt[i].waddr = i[2:0]; vt[i].wdata = 8'h10 + i[7:0];
            vt[i].ren = 1'b0; vt[i].raddr = 3'd0; vt[i].rdy = 1'b1;
            vt[i].acc = 1'b0; vt[i].vld = 1'b0; vt[i].rdata = 8'h00;
            vt[i].full = 8'((32'd1 << (i + 1)) - 1);
        end
        for (int k = 0; k < 16; k++) begin
            vt[8+k].wen = 1'b0; vt[8+k].waddr = 3'd0; vt[8+k].wdata = 8'h00;
            vt[8+k].ren = 1'b1; vt[8+k].raddr = 3'(k / 2); vt[8+k].rdy = 1'b1;
            vt[8+k].acc = 1'b1; vt[8+k].vld = 1'b1; vt[8+k].rdata = 8'h10 + 8'(k / 2);
            vt[8+k].full = 8'hFF << ((k + 1) / 2);
        end
        vt[24].wen = 1'b0; vt[24].waddr = 3'd0; vt[24].wdata = 8'h00;
        vt[24].ren = 1'b0; vt[24].raddr = 3'd0; vt[24].rdy = 1'b1;
        vt[24].acc = 1'b0; vt[24].vld = 1'b0; vt[24].rdata = 8'h17; vt[24].full = 8'h00;

        rst = 1'b0;
        do_reset();
        chk("reset_valid", 32'(RDataValid), 32'd0);
        chk("reset_rdata", 32'(RData), 32'h00);
        chk("reset_full", 32'(EntryFull), 32'h00);
        chk("reset_drained", 32'(Drained), 32'd1);
        chk("reset_errs", {30'd0, WrOvfErr, RdEmptyErr}, 32'd0);

        for (int v = 0; v < 25; v++) begin
            drive(vt[v].wen, vt[v].waddr, vt[v].wdata, vt[v].ren, vt[v].raddr, vt[v].rdy);
            chk($sformatf("vec%0d_accept", v), 32'(RAccept), 32'(vt[v].acc));
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(RDataValid), 32'(vt[v].vld));
            chk($sformatf("vec%0d_rdata", v), 32'(RData), 32'(vt[v].rdata));
            chk($sformatf("vec%0d_full", v), 32'(EntryFull), 32'(vt[v].full));
            chk($sformatf("vec%0d_drained", v), 32'(Drained), 32'(vt[v].full == 8'h00));
        end
        chk("stream_errs", {30'd0, WrOvfErr, RdEmptyErr}, 32'd0);

        // write wins over a freeing read on the same entry
        drive(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1); tick();
        chk("ww_first_read", 32'(RData), 32'h44);
        drive(1'b1, 3'd4, 8'h66, 1'b1, 3'd4, 1'b1);
        chk("ww_accept", 32'(RAccept), 32'd1);
        tick();
        chk("ww_bypass_data", 32'(RData), 32'h66);
        chk("ww_full4", 32'(EntryFull[4]), 32'd1);
        chk("ww_no_ovf", 32'(WrOvfErr), 32'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1); tick();
        chk("ww_cnt_reset_full", 32'(EntryFull[4]), 32'd1);
        tick();
        chk("ww_freed", 32'(EntryFull[4]), 32'd0);
        chk("ww_no_empty_err", 32'(RdEmptyErr), 32'd0);

        // downstream stall holds data and counters
        do_reset();
        drive(1'b1, 3'd1, 8'h55, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0); tick();
        chk("stall_first", 32'(RData), 32'h55);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d_accept", s), 32'(RAccept), 32'd0);
            tick();
            chk($sformatf("stall%0d_rdata", s), 32'(RData), 32'h55);
            chk($sformatf("stall%0d_valid", s), 32'(RDataValid), 32'd1);
            chk($sformatf("stall%0d_full", s), 32'(EntryFull), 32'h02);
        end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1);
        chk("stall_release_accept", 32'(RAccept), 32'd1);
        tick();
        chk("stall_release_full", 32'(EntryFull), 32'h00);

        // same-cycle write and read bypass on an empty entry
        do_reset();
        drive(1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 1'b1);
        chk("byp_accept", 32'(RAccept), 32'd1);
        tick();
        chk("byp_rdata", 32'(RData), 32'hA5);
        chk("byp_no_empty_err", 32'(RdEmptyErr), 32'd0);
        chk("byp_full", 32'(EntryFull), 32'h08);

        // overwrite of an occupied entry
        do_reset();
        drive(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b1); tick();
        chk("ovf_first_clean", 32'(WrOvfErr), 32'd0);
        drive(1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 1'b1); tick();
        chk("ovf_set", 32'(WrOvfErr), 32'd1);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1); tick();
        chk("ovf_second_word", 32'(RData), 32'h22);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1); tick();
        chk("ovf_sticky", 32'(WrOvfErr), 32'd1);

        // read of an empty entry after reset
        do_reset();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1); tick();
        chk("empty_err", 32'(RdEmptyErr), 32'd1);
        chk("empty_full5", 32'(EntryFull[5]), 32'd0);
        chk("empty_valid", 32'(RDataValid), 32'd1);

        // asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[2:0], 8'h30 + i[7:0], 1'b0, 3'd0, 1'b0); tick();
        end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0); tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("pre_rst_valid", 32'(RDataValid), 32'd1);
        chk("pre_rst_full", 32'(EntryFull), 32'h0F);
        chk("pre_rst_err", 32'(RdEmptyErr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(RDataValid), 32'd0);
        chk("async_rst_rdata", 32'(RData), 32'h00);
        chk("async_rst_full", 32'(EntryFull), 32'h00);
        chk("async_rst_drained", 32'(Drained), 32'd1);
        chk("async_rst_errs", {30'd0, WrOvfErr, RdEmptyErr}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1);
        chk("cold_accept", 32'(RAccept), 32'd1);
        tick();
        chk("cold_empty_err", 32'(RdEmptyErr), 32'd1);
        chk("cold_valid", 32'(RDataValid), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
